// File: rtl/pipelined_addsub_pkg.sv
// arith_pkg: operation encoding and configuration check for pipelined_addsub.
package arith_pkg;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    function automatic bit cfg_ok(int width, int stages);
        return stages >= 1 && stages <= width && width % stages == 0;
    endfunction
endpackage

// File: rtl/pipelined_addsub_if.sv
// pipelined_addsub_if: operand/result handshake bundle for pipelined_addsub.
interface pipelined_addsub_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    modport master (output in_valid, a, b, sub, out_ready,
                    input  in_ready, out_valid, sum, cout, ovf);
    modport slave  (input  in_valid, a, b, sub, out_ready,
                    output in_ready, out_valid, sum, cout, ovf);
endinterface

// File: rtl/pipelined_addsub_slice.sv
// adder_slice: combinational SW-bit ripple adder built from full-adder cells.
module adder_slice #(
    parameter int SW = 4
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] s,
    output logic          cout,
    output logic          c_msb_in
);
    logic [SW:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < SW; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout     = c[SW];
    assign c_msb_in = c[SW-1];
endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: STAGES-deep registered ripple adder/subtractor with a
// global-stall valid/ready handshake.
module pipelined_addsub
    import arith_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic              clk,
    input logic              rst_n,
    pipelined_addsub_if.slave bus
);
    localparam int SW = WIDTH / STAGES;
    localparam int L  = STAGES - 1;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_addsub: WIDTH must be a multiple of STAGES");
    end

    logic             stall;
    logic [WIDTH-1:0] a_r [STAGES];
    logic [WIDTH-1:0] b_r [STAGES];
    logic [WIDTH-1:0] s_r [STAGES];
    logic             c_r [STAGES];
    logic             v_r [STAGES];
    logic [SW-1:0]    s_c [STAGES];
    logic             co  [STAGES];
    logic             cm  [STAGES];
    logic             ovf_r;

    assign stall        = bus.out_valid & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_i, b_i, s_i, s_n;
        logic             c_i, v_i;
        // b_i is already conditionally inverted, so later stages never see sub
        if (k == 0) begin : g_head
            assign a_i = bus.a;
            assign b_i = bus.b ^ {WIDTH{bus.sub == OP_SUB}};
            assign c_i = bus.sub == OP_SUB;
            assign s_i = '0;
            assign v_i = bus.in_valid;
        end else begin : g_body
            assign a_i = a_r[k-1];
            assign b_i = b_r[k-1];
            assign c_i = c_r[k-1];
            assign s_i = s_r[k-1];
            assign v_i = v_r[k-1];
        end
        adder_slice #(.SW(SW)) u_slice (
            .a        (a_i[k*SW +: SW]),
            .b        (b_i[k*SW +: SW]),
            .cin      (c_i),
            .s        (s_c[k]),
            .cout     (co[k]),
            .c_msb_in (cm[k])
        );
        always_comb begin
            s_n               = s_i;
            s_n[k*SW +: SW]   = s_c[k];
        end
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_r[k] <= 1'b0;
                a_r[k] <= '0;
                b_r[k] <= '0;
                s_r[k] <= '0;
                c_r[k] <= 1'b0;
            end else if (!stall) begin
                v_r[k] <= v_i;
                a_r[k] <= a_i;
                b_r[k] <= b_i;
                s_r[k] <= s_n;
                c_r[k] <= co[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ovf_r <= 1'b0;
        else if (!stall) ovf_r <= co[L] ^ cm[L];
    end

    assign bus.out_valid = v_r[L];
    assign bus.sum       = s_r[L];
    assign bus.cout      = c_r[L];
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed table, backpressure and reset sequences on a
// 4-stage instance, plus a random sweep of 1- and 16-stage instances.
module tb_pipelined_addsub;
    typedef struct {
        logic [15:0] a, b;
        logic        sub;
        logic [15:0] s;
        logic        c, o;
    } vec_t;
    typedef struct {
        logic [15:0] s;
        logic        c, o;
        int          t;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   sweep_on = 1'b0;
    exp_t q [2][$];
    vec_t v [10];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_addsub_if #(.WIDTH(16)) bus4 ();
    pipelined_addsub_if #(.WIDTH(16)) bus1 ();
    pipelined_addsub_if #(.WIDTH(16)) bus16 ();

    pipelined_addsub #(.WIDTH(16), .STAGES(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    pipelined_addsub #(.WIDTH(16), .STAGES(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    pipelined_addsub #(.WIDTH(16), .STAGES(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", n, got, want, cyc);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic sub);
        exp_t        e;
        logic [15:0] bb;
        logic [16:0] r;
        bb  = sub ? ~b : b;
        r   = {1'b0, a} + {1'b0, bb} + {16'd0, sub};
        e.s = r[15:0];
        e.c = r[16];
        e.o = (a[15] == bb[15]) && (e.s[15] != a[15]);
        e.t = 0;
        return e;
    endfunction

    task automatic sb(input int d, input int st, input logic iv, input logic ir,
                      input logic [15:0] a, input logic [15:0] b, input logic sub,
                      input logic ov, input logic [15:0] s, input logic c, input logic o);
        exp_t e;
        if (ov) begin
            if (q[d].size() == 0) chk(d == 0 ? "sweep1_extra" : "sweep16_extra", {31'd0, ov}, 32'd0);
            else begin
                e = q[d].pop_front();
                chk(d == 0 ? "sweep1_beat" : "sweep16_beat",
                    {6'd0, s, c, o, 8'(cyc - e.t)}, {6'd0, e.s, e.c, e.o, 8'(st)});
            end
        end
        if (iv && ir) begin
            e   = model(a, b, sub);
            e.t = cyc;
            q[d].push_back(e);
        end
    endtask

    always @(negedge clk) if (sweep_on) begin
        sb(0, 1, bus1.in_valid, bus1.in_ready, bus1.a, bus1.b, bus1.sub,
           bus1.out_valid, bus1.sum, bus1.cout, bus1.ovf);
        sb(1, 16, bus16.in_valid, bus16.in_ready, bus16.a, bus16.b, bus16.sub,
           bus16.out_valid, bus16.sum, bus16.cout, bus16.ovf);
    end

    initial begin
        logic [15:0] ra [4];
        logic [15:0] rb [4];
        int sent, rcv;
        v[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        v[1] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        v[2] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        v[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        v[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        v[5] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0};
        v[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        v[7] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        v[8] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1};
        v[9] = '{16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        ra = '{16'h8001, 16'h1111, 16'h2222, 16'h3333};
        rb = '{16'h8000, 16'h1111, 16'h1111, 16'h1111};
        rst_n = 1'b0;
        bus4.in_valid = 0; bus4.a = 0; bus4.b = 0; bus4.sub = 0; bus4.out_ready = 1;
        bus1.in_valid = 0; bus1.a = 0; bus1.b = 0; bus1.sub = 0; bus1.out_ready = 1;
        bus16.in_valid = 0; bus16.a = 0; bus16.b = 0; bus16.sub = 0; bus16.out_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_valid", {31'd0, bus4.out_valid}, 32'd0);
        chk("reset_sum", {16'd0, bus4.sum}, 32'd0);
        chk("reset_cout", {31'd0, bus4.cout}, 32'd0);
        chk("reset_ovf", {31'd0, bus4.ovf}, 32'd0);
        chk("reset_ready", {31'd0, bus4.in_ready}, 32'd1);

        // directed table: one beat at a time, output expected exactly 4 cycles later
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bus4.in_valid = 1; bus4.a = v[i].a; bus4.b = v[i].b; bus4.sub = v[i].sub;
            for (int t = 1; t <= 4; t++) begin
                @(posedge clk); #1;
                if (t == 1) bus4.in_valid = 0;
                if (t == 3) chk("vec_early_valid", {31'd0, bus4.out_valid}, 32'd0);
            end
            chk("vec_valid", {31'd0, bus4.out_valid}, 32'd1);
            chk("vec_sum", {16'd0, bus4.sum}, {16'd0, v[i].s});
            chk("vec_cout", {31'd0, bus4.cout}, {31'd0, v[i].c});
            chk("vec_ovf", {31'd0, bus4.ovf}, {31'd0, v[i].o});
        end

        // backpressure: 8 back-to-back beats, consumer stalls cycles 6..8
        sent = 0; rcv = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            bus4.out_ready = !(c >= 6 && c < 9);
            bus4.in_valid  = sent < 8;
            bus4.a = 16'(sent); bus4.b = 16'(sent << 8); bus4.sub = 0;
            #1;
            chk("bp_ready", {31'd0, bus4.in_ready}, {31'd0, !(c >= 6 && c < 9)});
            if (bus4.out_valid) begin
                if (rcv < 8) chk("bp_beat", {14'd0, bus4.sum, bus4.cout, bus4.ovf}, {14'd0, 16'(rcv * 257), 2'b00});
                else chk("bp_extra_valid", {31'd0, bus4.out_valid}, 32'd0);
                if (bus4.out_ready) rcv++;
            end
            if (bus4.in_valid && bus4.in_ready) sent++;
        end
        chk("bp_received", rcv, 8);
        chk("bp_sent", sent, 8);

        // reset with three beats still in flight
        bus4.out_ready = 1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            bus4.in_valid = 1; bus4.a = ra[c]; bus4.b = rb[c]; bus4.sub = 0;
        end
        @(posedge clk); #1;
        bus4.in_valid = 0;
        chk("rst_pre_beat", {13'd0, bus4.out_valid, bus4.sum, bus4.cout, bus4.ovf}, {13'd0, 1'b1, 16'h0001, 1'b1, 1'b1});
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_valid", {31'd0, bus4.out_valid}, 32'd0);
        chk("rst_sum", {16'd0, bus4.sum}, 32'd0);
        chk("rst_cout", {31'd0, bus4.cout}, 32'd0);
        chk("rst_ovf", {31'd0, bus4.ovf}, 32'd0);
        repeat (8) begin
            @(posedge clk); #1;
            chk("rst_stale", {31'd0, bus4.out_valid}, 32'd0);
        end

        // random sweep of the 1- and 16-stage instances
        @(posedge clk); #1;
        sweep_on = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            bus1.in_valid = $urandom_range(3) != 0;
            bus1.a = 16'($urandom); bus1.b = 16'($urandom); bus1.sub = 1'($urandom);
            bus16.in_valid = bus1.in_valid; bus16.a = bus1.a; bus16.b = bus1.b; bus16.sub = bus1.sub;
        end
        @(posedge clk); #1;
        bus1.in_valid = 0; bus16.in_valid = 0;
        repeat (20) @(posedge clk);
        #1 sweep_on = 1'b0;
        chk("sweep1_drained", q[0].size(), 0);
        chk("sweep16_drained", q[1].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
